// File: rtl/io_console.sv
// io_console
// Memory-mapped console and halt device that snoops the CPU-RAM bus.
// CPU writes to the console register are queued in a small FIFO.
// The queue drains one byte at a time to a printer over a valid/ready
// handshake, with no more than one byte every DRAIN_DIV cycles.
// A magic value written to the halt register raises a sticky halt flag.
// A status register reports halt, overflow, full, empty and count.
//
// Ports:
//   clock       system clock, all state updates on the rising edge
//   reset       synchronous, active-high
//   address     CPU word address (shared with RAM)
//   write_en    CPU write strobe (shared with RAM)
//   data_in     CPU write data, big-endian bit numbering
//   io_sel      high when address hits one of the three registers
//   data_out    status word when the status register is addressed, else 0
//   char_valid  a byte is offered to the printer
//   char_data   FIFO head byte (0 when empty)
//   char_ready  printer accepts the offered byte
//   halt        sticky halt flag
//   overflow    sticky dropped-byte flag
module io_console #(
    parameter logic [16:0] HALT_ADDR    = 17'h00100,
    parameter logic [16:0] CONSOLE_ADDR = 17'h00101,
    parameter logic [16:0] STATUS_ADDR  = 17'h00102,
    parameter logic [31:0] HALT_CODE    = 32'h00010001,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DRAIN_DIV    = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [15:31] address,
    input  logic         write_en,
    input  logic [0:31]  data_in,
    output logic         io_sel,
    output logic [0:31]  data_out,
    output logic         char_valid,
    output logic [0:7]   char_data,
    input  logic         char_ready,
    output logic         halt,
    output logic         overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int PACE_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
    localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(DEPTH);
    localparam logic [PACE_W-1:0] PACE_RELOAD = PACE_W'(DRAIN_DIV - 1);

    logic [7:0]        mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PACE_W-1:0] pace_q, pace_d;
    logic              halt_q, halt_d;
    logic              overflow_q, overflow_d;

    logic sel_halt, sel_console, sel_status;
    logic fifo_full, fifo_empty;
    logic push_req, push, pop, drop;
    logic halt_write, status_clear;
    logic [31:0] status_word;

    always_comb begin
        sel_halt     = (address == HALT_ADDR);
        sel_console  = (address == CONSOLE_ADDR);
        sel_status   = (address == STATUS_ADDR);
        io_sel       = sel_halt | sel_console | sel_status;

        fifo_full    = (count_q == FULL_COUNT);
        fifo_empty   = (count_q == '0);

        // Outputs come from registers only so they stay stable until accepted.
        char_valid   = !fifo_empty && (pace_q == '0);
        char_data    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];

        pop          = char_valid && char_ready;
        push_req     = write_en && sel_console;
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push         = push_req && (!fifo_full || pop);
        drop         = push_req && fifo_full && !pop;

        halt_write   = write_en && sel_halt && (data_in == HALT_CODE);
        status_clear = write_en && sel_status && data_in[1];
    end

    // Status word in big-endian numbering: bit 0 (halt) is the MSB and the
    // count occupies the least significant bits.
    always_comb begin
        status_word              = '0;
        status_word[31]          = halt_q;
        status_word[30]          = overflow_q;
        status_word[29]          = fifo_full;
        status_word[28]          = fifo_empty;
        status_word[CNT_W-1:0]   = count_q;
        data_out                 = sel_status ? status_word : 32'h0;
        halt                     = halt_q;
        overflow                 = overflow_q;
    end

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        pace_d     = pace_q;
        halt_d     = halt_q;
        overflow_d = overflow_q;

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end

        // The pace counter spaces successive byte presentations.
        if (pop) begin
            pace_d = PACE_RELOAD;
        end else if (pace_q != '0) begin
            pace_d = pace_q - PACE_W'(1);
        end

        if (halt_write) begin
            halt_d = 1'b1;
        end

        // A dropped byte on the same edge as a clear request keeps the flag set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (status_clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            pace_q     <= '0;
            halt_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            pace_q     <= pace_d;
            halt_q     <= halt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: char_data is forced to 0 while empty.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= data_in[24:31];
        end
    end

endmodule

// File: tb/tb_io_console.sv
module tb_io_console;

   localparam logic [16:0] HALT_A    = 17'h00100;
   localparam logic [16:0] CONS_A    = 17'h00101;
   localparam logic [16:0] STAT_A    = 17'h00102;
   localparam logic [31:0] HALT_CODE = 32'h00010001;
   localparam int          DEPTH     = 8;
   localparam int          DRAIN_DIV = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [16:0] address = '0;
   logic        write_en = 1'b0;
   logic [31:0] data_in = '0;
   logic        char_ready = 1'b0;
   logic        io_sel;
   logic [31:0] data_out;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        halt;
   logic        overflow;

   io_console #(.DEPTH(DEPTH), .DRAIN_DIV(DRAIN_DIV)) dut (
      .clock(clock), .reset(reset), .address(address), .write_en(write_en),
      .data_in(data_in), .io_sel(io_sel), .data_out(data_out),
      .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
      .halt(halt), .overflow(overflow)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Reference model: number of queued bytes, cycles since the last accepted
   // byte, and the two sticky flags. Expected printer bytes live in expQ.
   int         mCount = 0;
   int         mGap = DRAIN_DIV;
   bit         mHalt = 1'b0;
   bit         mOvf = 1'b0;
   logic [7:0] expQ[$];
   logic [7:0] printed[$];
   int         popCyc[$];
   logic [7:0] expByte;
   bit         mPop, mPushReq, mAccept;

   function automatic bit modelValid();
      return (mCount > 0) && (mGap >= DRAIN_DIV - 1);
   endfunction

   function automatic logic [31:0] modelStatus();
      return {mHalt, mOvf, (mCount == DEPTH), (mCount == 0), 24'h0, 4'(mCount)};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model update on every rising edge using the inputs the DUT sees.
   always @(posedge clock) begin
      cyc++;
      if (reset) begin
         mCount = 0;
         mGap   = DRAIN_DIV;
         mHalt  = 1'b0;
         mOvf   = 1'b0;
         expQ.delete();
      end else begin
         mPop     = modelValid() && char_ready;
         mPushReq = write_en && (address == CONS_A);
         mAccept  = mPushReq && ((mCount < DEPTH) || mPop);
         if (mAccept) expQ.push_back(data_in[7:0]);
         if (mPushReq && !mAccept) mOvf = 1'b1;
         else if (write_en && (address == STAT_A) && data_in[30]) mOvf = 1'b0;
         if (write_en && (address == HALT_A) && (data_in == HALT_CODE)) mHalt = 1'b1;
         mCount = mCount + (mAccept ? 1 : 0) - (mPop ? 1 : 0);
         if (mPop) mGap = 0;
         else if (mGap < 1000) mGap = mGap + 1;
      end
   end

   // Monitor: compares outputs each cycle and scores every printer handshake.
   always @(negedge clock) begin
      checkOutput("char_valid", 32'(char_valid), 32'(modelValid()));
      checkOutput("halt", 32'(halt), 32'(mHalt));
      checkOutput("overflow", 32'(overflow), 32'(mOvf));
      checkOutput("io_sel", 32'(io_sel),
                  32'((address == HALT_A) || (address == CONS_A) || (address == STAT_A)));
      checkOutput("data_out", data_out, (address == STAT_A) ? modelStatus() : 32'h0);
      if (mCount == 0) checkOutput("char_data_empty", 32'(char_data), 32'h0);
      if (!reset && char_valid && char_ready) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_byte: got %h expected none (cycle %0d)", char_data, cyc);
         end else begin
            expByte = expQ.pop_front();
            checkOutput("char_data", 32'(char_data), 32'(expByte));
         end
         printed.push_back(char_data);
         popCyc.push_back(cyc);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [16:0] a, input logic we, input logic [31:0] d, input logic rdy);
      address    = a;
      write_en   = we;
      data_in    = d;
      char_ready = rdy;
      tick(1);
      write_en   = 1'b0;
   endtask

   task automatic readStatus(input string name, input logic [31:0] exp);
      address  = STAT_A;
      write_en = 1'b0;
      #1;
      checkOutput(name, data_out, exp);
   endtask

   initial begin
      int r;
      logic [16:0] a;
      logic [31:0] d;

      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      checkOutput("reset_valid", 32'(char_valid), 32'h0);
      checkOutput("reset_halt", 32'(halt), 32'h0);
      checkOutput("reset_ovf", 32'(overflow), 32'h0);
      checkOutput("reset_char_data", 32'(char_data), 32'h0);
      readStatus("reset_status", 32'h10000000);

      // Two bytes with the printer always ready.
      printed.delete();
      popCyc.delete();
      applyStimulus(CONS_A, 1'b1, 32'h00000048, 1'b1);
      applyStimulus(CONS_A, 1'b1, 32'h00000069, 1'b1);
      tick(12);
      checkOutput("t1_count", 32'(printed.size()), 32'd2);
      if (printed.size() == 2) begin
         checkOutput("t1_byte0", 32'(printed[0]), 32'h48);
         checkOutput("t1_byte1", 32'(printed[1]), 32'h69);
         checkOutput("t1_spacing", 32'(popCyc[1] - popCyc[0]), 32'(DRAIN_DIV));
      end
      readStatus("t1_status", 32'h10000000);

      // Nine bytes into a stalled FIFO: the ninth is dropped.
      for (int i = 1; i <= 9; i++) applyStimulus(CONS_A, 1'b1, 32'(i), 1'b0);
      readStatus("t2_status", 32'h60000008);
      applyStimulus(STAT_A, 1'b1, 32'h40000000, 1'b0);
      checkOutput("t7_ovf_clear", 32'(overflow), 32'h0);
      readStatus("t7_status", 32'h20000008);
      printed.delete();
      char_ready = 1'b1;
      tick(DEPTH * DRAIN_DIV + 8);
      char_ready = 1'b0;
      checkOutput("t2_printed_n", 32'(printed.size()), 32'd8);
      for (int i = 0; i < printed.size(); i++)
         checkOutput("t2_printed", 32'(printed[i]), 32'(i + 1));

      // Full FIFO with pop and push on the same edge.
      for (int i = 0; i < DEPTH; i++) applyStimulus(CONS_A, 1'b1, 32'h11 + 32'(i), 1'b0);
      checkOutput("t3_valid", 32'(char_valid), 32'h1);
      applyStimulus(CONS_A, 1'b1, 32'h00000099, 1'b1);
      char_ready = 1'b0;
      checkOutput("t3_ovf", 32'(overflow), 32'h0);
      readStatus("t3_status", 32'h20000008);
      printed.delete();
      char_ready = 1'b1;
      tick(DEPTH * DRAIN_DIV + 8);
      char_ready = 1'b0;
      checkOutput("t3_printed_n", 32'(printed.size()), 32'd8);
      if (printed.size() == 8) begin
         checkOutput("t3_first", 32'(printed[0]), 32'h12);
         checkOutput("t3_last", 32'(printed[7]), 32'h99);
      end

      // Halt register.
      applyStimulus(HALT_A, 1'b1, 32'h00010000, 1'b0);
      checkOutput("halt_wrong_code", 32'(halt), 32'h0);
      applyStimulus(HALT_A, 1'b1, HALT_CODE, 1'b0);
      checkOutput("halt_set", 32'(halt), 32'h1);
      applyStimulus(HALT_A, 1'b1, 32'h0, 1'b0);
      applyStimulus(STAT_A, 1'b1, 32'hFFFFFFFF, 1'b0);
      checkOutput("halt_sticky", 32'(halt), 32'h1);

      // Reset while bytes are waiting.
      for (int i = 0; i < 3; i++) applyStimulus(CONS_A, 1'b1, 32'hA1 + 32'(i), 1'b0);
      checkOutput("pre_reset_valid", 32'(char_valid), 32'h1);
      readStatus("pre_reset_status", 32'h80000003);
      reset = 1'b1;
      char_ready = 1'b1;
      tick(1);
      reset = 1'b0;
      char_ready = 1'b0;
      checkOutput("post_reset_valid", 32'(char_valid), 32'h0);
      checkOutput("post_reset_halt", 32'(halt), 32'h0);
      checkOutput("post_reset_ovf", 32'(overflow), 32'h0);
      readStatus("post_reset_status", 32'h10000000);
      tick(1);

      // Address decode around the register window.
      for (int ai = 32'h0FE; ai <= 32'h104; ai++) begin
         address  = 17'(ai);
         write_en = 1'b0;
         #1;
         checkOutput("io_sel_sweep", 32'(io_sel), 32'((ai >= 32'h100) && (ai <= 32'h102)));
         if (ai == 32'h103) checkOutput("data_out_103", data_out, 32'h0);
         tick(1);
      end

      // Randomised traffic checked by the model and monitor.
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 4));
         case (r)
            0: begin a = HALT_A; d = ($urandom_range(0, 1) == 1) ? HALT_CODE : $urandom; end
            1, 2: begin a = CONS_A; d = $urandom; end
            3: begin a = STAT_A; d = $urandom; end
            default: begin a = 17'($urandom_range(0, 32'h1FFFF)); d = $urandom; end
         endcase
         reset = ($urandom_range(0, 99) == 0);
         applyStimulus(a, ($urandom_range(0, 3) != 0), d, ($urandom_range(0, 9) < 3));
      end
      reset = 1'b0;
      write_en = 1'b0;
      char_ready = 1'b1;
      tick(DEPTH * DRAIN_DIV + 10);
      checkOutput("drain_empty", 32'(expQ.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/io_console.md
# io_console

Memory-mapped console and halt device that sits on the CPU–RAM bus beside the word memory and snoops the same address, write-enable and write-data lines. CPU writes to the console register are buffered in a small FIFO and drained one byte at a time to a bench-side printer over a valid/ready handshake. A magic write to the halt register raises a sticky `halt` flag that ends simulation cleanly. A status register reports FIFO and flag state to the CPU.

## Interface
Parameters:
- `HALT_ADDR`, 17'h00100, word address of halt register
- `CONSOLE_ADDR`, 17'h00101, word address of console data register
- `STATUS_ADDR`, 17'h00102, word address of status register
- `HALT_CODE`, 32'h00010001, data value that triggers halt
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `DRAIN_DIV`, 4, minimum cycles between byte presentations; ≥1

Ports:
- `clock`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `address`  in  [15:31]  CPU word address, shared with RAM
- `write_en`  in  1  CPU write strobe, shared with RAM
- `data_in`  in  [0:31]  CPU write data, big-endian bit numbering
- `io_sel`  out  1  combinational; high when `address` equals any of the three register addresses
- `data_out`  out  [0:31]  combinational read data; status word when `address`==`STATUS_ADDR`, else 0
- `char_valid`  out  1  byte available to printer
- `char_data`  out  [0:7]  FIFO head byte
- `char_ready`  in  1  printer accepts byte
- `halt`  out  1  sticky halt flag
- `overflow`  out  1  sticky dropped-byte flag

## Operation
- Reset clears FIFO pointers, count, `halt`, `overflow`, and pace counter. After reset: `char_valid`=0, `halt`=0, `overflow`=0, `char_data`=0.
- Console write (`write_en` && `address`==`CONSOLE_ADDR`): push `data_in[24:31]`. If FIFO is full and no pop occurs on the same edge, the byte is dropped and `overflow` is set.
- Pop on `char_valid && char_ready`; pace counter loads `DRAIN_DIV-1`.
- Push and pop on the same edge: both take effect, including when full. Count is unchanged and no overflow occurs.
- `char_valid` = !empty && pace==0, derived from registers only. `char_data` = head entry when not empty, 0 when empty.
- Pace counter decrements each cycle while nonzero, independent of FIFO state.
- Once raised, `char_valid` and `char_data` hold stable until accepted.
- Halt write (`write_en` && `address`==`HALT_ADDR` && `data_in`==`HALT_CODE`): set `halt`. Any other data written to `HALT_ADDR` is ignored. Only reset clears `halt`.
- Status write (`address`==`STATUS_ADDR`): if `data_in[1]`=1, clear `overflow`. If an overflowing push occurs on the same edge, set wins.
- Status word layout:
  - bit 0 = `halt`
  - bit 1 = `overflow`
  - bit 2 = full
  - bit 3 = empty
  - bits [4:27] = 0
  - bits [28:31] = count (0..DEPTH; wider field if DEPTH>15)
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- The block never drives RAM. Bus-level integration uses `io_sel` to mux `data_out` over RAM read data; RAM writes to these addresses are harmless.

## Timing
- Push at edge k: `char_valid` high in the cycle after edge k, if pace==0.
- Pop at edge p: `char_valid` low for `DRAIN_DIV-1` cycles, then high again if not empty.
- `DRAIN_DIV`=1 allows back-to-back pops.
- Sustained throughput with `char_ready` tied high is 1 byte per `DRAIN_DIV` cycles.
- `halt` high in the cycle after the qualifying write edge.
- Status read is zero-latency combinational and reflects state as of the last edge.
- Reset asserted mid-drain: the FIFO contents are discarded and `char_valid` is 0 in the cycle after the reset edge, regardless of `char_ready`.

## Test plan
- Reset, then write 32'h00000048 and 32'h00000069 to 17'h00101, `char_ready`=1, `DRAIN_DIV`=4:
  - `char_data` shows 8'h48, then 8'h69
  - `char_valid` pulses 4 cycles apart
  - status afterwards reads 32'h10000000 (empty, count 0)
- `char_ready`=0; write 9 bytes 8'h01..8'h09:
  - status reads 32'h60000008 (overflow, full, count 8)
  - on release, the printer receives 01..08; 09 is lost
- With FIFO full, pop and push on the same edge:
  - count stays 8, `overflow` stays 0
  - the new byte is later emitted last
- Write 32'h00010000 to 17'h00100 → `halt` stays 0.
- Write 32'h00010001 to 17'h00100 → `halt`=1 next cycle and persists through further writes.
- Assert `reset` while 3 bytes are queued and `char_valid`=1:
  - next cycle `char_valid`=0
  - status reads 32'h10000000
  - `halt` and `overflow` are 0
- Write 32'h40000000 to `STATUS_ADDR` after an overflow → `overflow` clears next cycle.
- Check `io_sel`: 1 only for addresses 17'h00100..17'h00102; `data_out` is 0 for address 17'h00103.
